// File: rtl/mem_arbiter_if.sv
// Bundles the CPU, DMA and memory-side signals of the memory arbiter.
// The arbiter takes the slave view; the surrounding system takes the master view.
interface mem_arbiter_if #(
  parameter int unsigned N = 32,
  parameter int unsigned M = 16
);
  logic [N-1:0] c_addr;
  logic [M-1:0] c_wdata;
  logic         c_re;
  logic         c_we;
  logic         c_ready;
  logic [M-1:0] c_rdata;

  logic         d_req;
  logic         d_we;
  logic [N-1:0] d_addr;
  logic [M-1:0] d_wdata;
  logic         d_ack;
  logic [M-1:0] d_rdata;

  logic [N-1:0] mem_addr;
  logic [M-1:0] mem_wdata;
  logic         mem_re;
  logic         mem_we;
  logic [M-1:0] mem_rdata;
  logic         mem_ready;

  logic         w_overflow;

  modport slave (
    input  c_addr, c_wdata, c_re, c_we,
    output c_ready, c_rdata,
    input  d_req, d_we, d_addr, d_wdata,
    output d_ack, d_rdata,
    output mem_addr, mem_wdata, mem_re, mem_we,
    input  mem_rdata, mem_ready,
    output w_overflow
  );

  modport master (
    output c_addr, c_wdata, c_re, c_we,
    input  c_ready, c_rdata,
    output d_req, d_we, d_addr, d_wdata,
    input  d_ack, d_rdata,
    input  mem_addr, mem_wdata, mem_re, mem_we,
    output mem_rdata, mem_ready,
    input  w_overflow
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates one memory port between CPU reads, posted CPU writes and a DMA engine,
// with a one-entry write buffer and a starvation limit that forces DMA through.
module mem_arbiter #(
  parameter int unsigned N        = 32,
  parameter int unsigned M        = 16,
  parameter int unsigned MAXBURST = 8
) (
  input logic          clk_i,
  input logic          rst_ni,
  mem_arbiter_if.slave bus
);
  localparam int unsigned   SW        = $clog2(MAXBURST + 1);
  localparam logic [SW-1:0] StarveMax = SW'(MAXBURST);

  typedef enum logic [1:0] {StIdle, StGcpu, StGdma, StGwb} state_e;

  state_e        state_q, state_d;
  logic          wb_full_q, wb_full_d;
  logic [N-1:0]  wb_addr_q, wb_addr_d;
  logic [M-1:0]  wb_data_q, wb_data_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          ovf_q, ovf_d;
  logic          wb_done;
  logic          wb_capture;

  always_comb begin
    wb_done    = (state_q == StGwb) && bus.mem_ready;
    wb_capture = bus.c_we && (!wb_full_q || wb_done);

    wb_full_d = wb_full_q;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    ovf_d     = ovf_q;
    if (wb_capture) begin
      wb_full_d = 1'b1;
      wb_addr_d = bus.c_addr;
      wb_data_d = bus.c_wdata;
    end else if (bus.c_we) begin
      ovf_d = 1'b1;
    end else if (wb_done) begin
      wb_full_d = 1'b0;
    end

    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (bus.d_req && starve_q == StarveMax) begin
          state_d = StGdma;
        end else if (wb_full_q) begin
          state_d = StGwb;
        end else if (bus.c_re && !bus.c_we) begin
          // A write posted this cycle must reach memory before any read.
          state_d = StGcpu;
        end else if (bus.d_req) begin
          state_d = StGdma;
        end
      end
      default: begin
        if (bus.mem_ready) state_d = StIdle;
      end
    endcase

    starve_d = starve_q;
    if (!bus.d_req || (state_q == StIdle && state_d == StGdma)) begin
      starve_d = '0;
    end else if ((state_q == StGcpu || state_q == StGwb) && bus.mem_ready &&
                 starve_q != StarveMax) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      wb_full_q <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      starve_q  <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wb_full_q <= wb_full_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
      starve_q  <= starve_d;
      ovf_q     <= ovf_d;
    end
  end

  // Memory side is decoded straight from the grant so reset silences it at once.
  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_re    = 1'b0;
    bus.mem_we    = 1'b0;
    case (state_q)
      StGcpu: begin
        bus.mem_addr = bus.c_addr;
        bus.mem_re   = 1'b1;
      end
      StGdma: begin
        bus.mem_addr  = bus.d_addr;
        bus.mem_wdata = bus.d_wdata;
        bus.mem_re    = !bus.d_we;
        bus.mem_we    = bus.d_we;
      end
      StGwb: begin
        bus.mem_addr  = wb_addr_q;
        bus.mem_wdata = wb_data_q;
        bus.mem_we    = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.c_ready    = (state_q == StGcpu) && bus.mem_ready;
  assign bus.d_ack      = (state_q == StGdma) && bus.mem_ready;
  assign bus.c_rdata    = bus.mem_rdata;
  assign bus.d_rdata    = bus.mem_rdata;
  assign bus.w_overflow = ovf_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios with literal expectations,
// then random traffic compared every cycle against a transaction-level model.
module tb_mem_arbiter;
  localparam int MAXB = 8;

  logic clk;
  logic rst_n;

  mem_arbiter_if #(.N(32), .M(16)) bus ();

  mem_arbiter #(.N(32), .M(16), .MAXBURST(MAXB)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: who owns the memory port, the posted-write queue (capacity 1), the
  // sticky overflow flag, and how many CPU-side accesses finished while DMA waited.
  typedef enum int {OwnNone, OwnCpu, OwnDma, OwnWb} owner_t;
  typedef struct packed {
    logic [31:0] a;
    logic [15:0] d;
  } wb_t;

  owner_t      owner = OwnNone;
  owner_t      nxt;
  wb_t         wbq[$];
  bit          ovf = 0;
  int          cpu_wins = 0;
  bit          done, wb_busy;
  logic        e_re, e_we, e_cready, e_dack;
  logic [31:0] e_addr;
  logic [15:0] e_wdata;
  bit          exp_cready_last = 0;
  bit          exp_dack_last = 0;

  initial forever begin
    @(negedge clk);
    #2;
    if (!rst_n) begin
      owner = OwnNone;
      wbq.delete();
      ovf = 0;
      cpu_wins = 0;
    end
    e_re = 0; e_we = 0; e_addr = '0; e_wdata = '0;
    case (owner)
      OwnCpu: begin e_re = 1; e_addr = bus.c_addr; end
      OwnDma: begin
        e_re = !bus.d_we; e_we = bus.d_we; e_addr = bus.d_addr; e_wdata = bus.d_wdata;
      end
      OwnWb:  begin e_we = 1; e_addr = wbq[0].a; e_wdata = wbq[0].d; end
      default: ;
    endcase
    e_cready = (owner == OwnCpu) && bus.mem_ready;
    e_dack   = (owner == OwnDma) && bus.mem_ready;
    check("mem_re", bus.mem_re, e_re);
    check("mem_we", bus.mem_we, e_we);
    check("mem_addr", bus.mem_addr, e_addr);
    check("mem_wdata", bus.mem_wdata, e_wdata);
    check("c_ready", bus.c_ready, e_cready);
    check("d_ack", bus.d_ack, e_dack);
    check("c_rdata", bus.c_rdata, bus.mem_rdata);
    check("d_rdata", bus.d_rdata, bus.mem_rdata);
    check("w_overflow", bus.w_overflow, ovf);
    exp_cready_last = e_cready;
    exp_dack_last   = e_dack;

    if (rst_n) begin
      done    = (owner != OwnNone) && bus.mem_ready;
      wb_busy = wbq.size() != 0;
      nxt     = owner;
      if (owner == OwnNone) begin
        if (bus.d_req && cpu_wins == MAXB) nxt = OwnDma;
        else if (wb_busy) nxt = OwnWb;
        else if (bus.c_re && !bus.c_we) nxt = OwnCpu;
        else if (bus.d_req) nxt = OwnDma;
      end else if (done) begin
        nxt = OwnNone;
      end
      if (!bus.d_req || (owner == OwnNone && nxt == OwnDma)) cpu_wins = 0;
      else if ((owner == OwnCpu || owner == OwnWb) && done && cpu_wins < MAXB) cpu_wins++;
      if (owner == OwnWb && done) void'(wbq.pop_front());
      if (bus.c_we) begin
        if (wbq.size() == 0) wbq.push_back('{a: bus.c_addr, d: bus.c_wdata});
        else ovf = 1;
      end
      owner = nxt;
    end
  end

  int cpu_n, ack_n, guard, resumed;

  initial begin
    rst_n = 0;
    bus.c_addr = '0; bus.c_wdata = '0; bus.c_re = 0; bus.c_we = 0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.mem_rdata = '0; bus.mem_ready = 0;

    @(negedge clk);
    @(negedge clk);
    #3;
    check("rst_mem_re", bus.mem_re, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_overflow", bus.w_overflow, 0);
    @(negedge clk);
    rst_n = 1;

    // Simple CPU read, memory ready on the first grant cycle.
    bus.c_re = 1; bus.c_addr = 32'h0000_1000; bus.mem_ready = 1; bus.mem_rdata = 16'h1234;
    #3 check("rd_idle_re", bus.mem_re, 0);
    @(negedge clk);
    #3;
    check("rd_re", bus.mem_re, 1);
    check("rd_addr", bus.mem_addr, 32'h0000_1000);
    check("rd_ready", bus.c_ready, 1);
    check("rd_data", bus.c_rdata, 16'h1234);
    @(negedge clk);
    bus.c_re = 0;
    #3 check("rd_done", bus.c_ready, 0);

    // Posted write during a 3-cycle DMA read, then drain, then CPU read.
    @(negedge clk);
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h400; bus.mem_ready = 0;
    @(negedge clk);
    bus.c_we = 1; bus.c_addr = 32'h20; bus.c_wdata = 16'hBEEF;
    #3;
    check("pw_dma_re", bus.mem_re, 1);
    check("pw_dma_addr", bus.mem_addr, 32'h400);
    @(negedge clk);
    bus.c_we = 0;
    #3 check("pw_dma_wait", bus.d_ack, 0);
    @(negedge clk);
    bus.mem_ready = 1; bus.mem_rdata = 16'h9999;
    #3;
    check("pw_dma_ack", bus.d_ack, 1);
    check("pw_dma_rdata", bus.d_rdata, 16'h9999);
    @(negedge clk);
    bus.d_req = 0; bus.c_re = 1; bus.c_addr = 32'h20; bus.mem_ready = 0;
    #3 check("pw_idle_we", bus.mem_we, 0);
    @(negedge clk);
    bus.mem_ready = 1;
    #3;
    check("pw_wb_we", bus.mem_we, 1);
    check("pw_wb_addr", bus.mem_addr, 32'h20);
    check("pw_wb_data", bus.mem_wdata, 16'hBEEF);
    check("pw_wb_noread", bus.c_ready, 0);
    @(negedge clk);
    #3 check("pw_idle2_re", bus.mem_re, 0);
    @(negedge clk);
    #3;
    check("pw_rd_re", bus.mem_re, 1);
    check("pw_rd_ready", bus.c_ready, 1);
    @(negedge clk);
    bus.c_re = 0;

    // Second write while the buffer is full is dropped; first drains intact.
    @(negedge clk);
    bus.c_we = 1; bus.c_addr = 32'h30; bus.c_wdata = 16'h1111; bus.mem_ready = 0;
    @(negedge clk);
    bus.c_addr = 32'h40; bus.c_wdata = 16'h2222;
    #3 check("ov_not_yet", bus.w_overflow, 0);
    @(negedge clk);
    bus.c_we = 0;
    #3;
    check("ov_flag", bus.w_overflow, 1);
    check("ov_wb_addr", bus.mem_addr, 32'h30);
    check("ov_wb_data", bus.mem_wdata, 16'h1111);
    @(negedge clk);
    bus.mem_ready = 1;
    #3 check("ov_wb_addr2", bus.mem_addr, 32'h30);
    @(negedge clk);
    bus.mem_ready = 0;
    #3;
    check("ov_idle_we", bus.mem_we, 0);
    check("ov_sticky", bus.w_overflow, 1);

    // Starvation limit: continuous CPU reads with DMA waiting.
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    bus.c_re = 1; bus.c_addr = 32'h500;
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h600; bus.d_wdata = 16'hAAAA;
    bus.mem_ready = 1;
    #3 check("st_ovf_cleared", bus.w_overflow, 0);
    cpu_n = 0; ack_n = 0; guard = 0;
    while (ack_n == 0 && guard < 40) begin
      if (guard != 0) #3;
      if (bus.c_ready) cpu_n++;
      if (bus.d_ack) begin
        ack_n++;
        check("st_dma_we", bus.mem_we, 1);
      end
      guard++;
      @(negedge clk);
    end
    bus.d_req = 0;
    check("st_cpu_grants", cpu_n, 8);
    check("st_dma_acks", ack_n, 1);
    resumed = 0; guard = 0;
    while (resumed == 0 && guard < 6) begin
      #3;
      if (bus.c_ready) resumed = 1;
      guard++;
      @(negedge clk);
    end
    check("st_cpu_resumed", resumed, 1);
    bus.c_re = 0;

    // Reset in the middle of a stalled DMA write.
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h700; bus.d_wdata = 16'h5555;
    bus.mem_ready = 0;
    @(negedge clk);
    #3;
    check("rs_we_before", bus.mem_we, 1);
    check("rs_addr_before", bus.mem_addr, 32'h700);
    bus.mem_ready = 1;
    rst_n = 0;
    #1;
    check("rs_we_drop", bus.mem_we, 0);
    check("rs_no_ack", bus.d_ack, 0);
    check("rs_addr_zero", bus.mem_addr, 0);
    @(negedge clk);
    bus.d_req = 0; bus.mem_ready = 0;
    @(negedge clk);
    rst_n = 1;
    #3;
    check("rs_idle_we", bus.mem_we, 0);
    check("rs_idle_re", bus.mem_re, 0);
    check("rs_overflow", bus.w_overflow, 0);

    // Random traffic; the model checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst_n = !(i >= 1500 && i < 1502);
      bus.mem_ready = $urandom_range(0, 2) != 0;
      bus.mem_rdata = 16'($urandom);
      if (bus.c_re && exp_cready_last) bus.c_re = 0;
      bus.c_we = 0;
      if (!bus.c_re && $urandom_range(0, 9) < 4) begin
        bus.c_re = 1;
        bus.c_addr = $urandom;
      end
      if ($urandom_range(0, 3) == 0) begin
        bus.c_we = 1;
        bus.c_wdata = 16'($urandom);
        if (!bus.c_re) bus.c_addr = $urandom;
      end
      if (bus.d_req && exp_dack_last) bus.d_req = 0;
      if (!bus.d_req && $urandom_range(0, 9) < 3) begin
        bus.d_req = 1;
        bus.d_we = 1'($urandom_range(0, 1));
        bus.d_addr = $urandom;
        bus.d_wdata = 16'($urandom);
      end
    end

    @(negedge clk);
    #4;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter N, default 32, address bus width.
REQ-002 Parameter M, default 16, data bus width.
REQ-003 Parameter MAXBURST, default 8, max consecutive CPU-side grants while DMA waits.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 cAddr  input  N  CPU address.
REQ-007 cWData  input  M  CPU write data.
REQ-008 cRE, cWE  input  1 each  CPU read and write strobes.
REQ-009 cReady  output  1  CPU read completes this cycle; CPU stalls while cRE=1 and cReady=0.
REQ-010 cRData  output  M  CPU read data, a direct copy of memRead.
REQ-011 dReq, dWE  input  1 each  DMA request; dWE=1 write, 0 read.
REQ-012 dAddr, dWData  input  N, M  DMA address and write data, held stable while dReq=1.
REQ-013 dAck  output  1  one-cycle pulse on DMA access completion.
REQ-014 dRData  output  M  DMA read data, a direct copy of memRead.
REQ-015 memAddr, memWrite  output  N, M  memory address and write data.
REQ-016 memRE, memWE  output  1 each  memory read and write enables.
REQ-017 memRead  input  M  memory read data.
REQ-018 memReady  input  1  current memory access completes this cycle.
REQ-019 wOverflow  output  1  sticky: a CPU write was dropped.

Function
REQ-020 FSM states: IDLE, GCPU (CPU read), GDMA, GWB (drain write buffer).
REQ-021 Memory outputs SHALL be driven only in grant states; in IDLE, memRE=memWE=0 and memAddr=memWrite=0.
REQ-022 GCPU: memAddr=cAddr, memRE=1; GDMA: memAddr=dAddr, memRE=!dWE, memWE=dWE, memWrite=dWData; GWB: buffered addr/data, memWE=1.
REQ-023 A grant state SHALL hold until a cycle with memReady=1, then return to IDLE at the next edge; minimum access is 2 cycles (IDLE + grant).
REQ-024 IDLE priority: DMA if dReq=1 and starve==MAXBURST; else GWB if buffer full; else GCPU if cRE=1; else GDMA if dReq=1; else stay in IDLE.
REQ-025 CPU writes are posted: a cycle with cWE=1 and an empty buffer (or a buffer completing in GWB this cycle) SHALL latch cAddr/cWData and set full.
REQ-026 cWE=1 while the buffer is full and not completing SHALL drop the write and set wOverflow; buffer contents stay unchanged.
REQ-027 Buffer full SHALL clear on GWB completion unless a new write is captured in the same cycle.
REQ-028 A CPU read SHALL never be granted while the buffer is full, so read-after-write is ordered.
REQ-029 cReady=1 only in GCPU with memReady=1; otherwise 0.
REQ-030 dAck=1 only in GDMA with memReady=1, registered-free (same cycle as completion).
REQ-031 starve counter (width clog2(MAXBURST+1)) SHALL increment, saturating at MAXBURST, on each GCPU/GWB completion while dReq=1.
REQ-032 starve SHALL clear on GDMA entry or in any cycle with dReq=0.
REQ-033 If a requester drops its request mid-grant, the arbiter SHALL still wait for memReady; results are discarded.

Reset
REQ-034 rst=0 SHALL immediately force: state IDLE, buffer empty, starve=0, wOverflow=0, memRE=memWE=0, cReady=0, dAck=0.
REQ-035 Reset mid-access SHALL abandon the access; a buffered write is lost; operation resumes in IDLE on the first edge after rst=1.

Verification
REQ-036 CPU read cAddr=0x00001000, memReady high on the 1st grant cycle -> memRE in cycle 2, cReady=1 in the same cycle, cRData=memRead.
REQ-037 cWE with addr 0x20, data 0xBEEF while GDMA is busy 3 cycles -> buffer holds it; GWB follows and memWE=1 with memAddr=0x20, memWrite=0xBEEF; then CPU read.
REQ-038 Second cWE while the buffer is full and memReady=0 -> write dropped, wOverflow=1 until reset; the first write drains intact.
REQ-039 cRE held continuously, dReq=1, MAXBURST=8 -> exactly 8 CPU grants, then one GDMA with dAck pulse, then CPU resumes.
REQ-040 rst low during GDMA with memReady=0 -> memWE drops same cycle, no dAck, state IDLE, wOverflow=0.
